// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Program sequencer for the TPU datapath. A small loadable program memory is
// stepped through a FETCH/EXECUTE machine that drives the control strobes used
// by weight memory, the unified buffer, input setup and the MMU.
//
// Optional feature (compile-time macro SEQ_LOOP_EN):
//   When defined, opcode 3'b110 is LOOP (target = ir[7:0], repeat = ir[12:8]),
//   giving one level of hardware looping. When undefined, 3'b110 traps to ERROR.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous active-low reset
//   start         in   start program at pc 0 (only while not busy)
//   stall         in   hold in FETCH while high
//   imem_we       in   program write enable (dropped while busy)
//   imem_waddr    in   program write address
//   imem_wdata    in   program write data
//   base_address  out  last LOAD_ADDR operand
//   load_weight   out  one-cycle strobe
//   load_input    out  one-cycle strobe
//   store         out  one-cycle strobe
//   valid         out  high during every COMPUTE cycle
//   busy          out  program running
//   done          out  program ended via HALT or end of memory
//   error         out  illegal opcode trapped
//   pc            out  current program counter
// -----------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int IMEM_DEPTH     = 16,
    parameter int INSTR_W        = 16,
    parameter int ADDR_W         = 13,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INSTR_W-1:0]            imem_wdata,
    output logic [ADDR_W-1:0]             base_address,
    output logic                          load_weight,
    output logic                          load_input,
    output logic                          store,
    output logic                          valid,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);

    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(IMEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    localparam logic [2:0] OP_HALT        = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_LOAD_INPUT  = 3'b011;
    localparam logic [2:0] OP_COMPUTE     = 3'b100;
    localparam logic [2:0] OP_STORE       = 3'b101;
`ifdef SEQ_LOOP_EN
    localparam logic [2:0] OP_LOOP        = 3'b110;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXECUTE,
        S_COMPUTE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lw_q, lw_d;
    logic                 li_q, li_d;
    logic                 st_q, st_d;
    logic                 valid_q, busy_q, done_q, error_q;
    logic                 advance;
    logic [2:0]           opcode;

`ifdef SEQ_LOOP_EN
    logic [4:0]           loop_cnt_q, loop_cnt_d;
    logic                 loop_active_q, loop_active_d;
    logic [4:0]           loop_r;
    logic [PC_W-1:0]      loop_tgt;
`endif

    // Program memory: no reset, contents survive reset.
    logic [INSTR_W-1:0]   imem_q [IMEM_DEPTH];

    // Writes are dropped while a program runs so the code under execution
    // can never change underneath the fetch.
    always_ff @(posedge clk) begin
        if (imem_we && !busy_q) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    assign opcode = ir_q[INSTR_W-1 -: 3];

`ifdef SEQ_LOOP_EN
    assign loop_r   = ir_q[12:8];
    assign loop_tgt = PC_W'(ir_q[7:0]);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        lw_d    = 1'b0;
        li_d    = 1'b0;
        st_d    = 1'b0;
        advance = 1'b0;
`ifdef SEQ_LOOP_EN
        loop_cnt_d    = loop_cnt_q;
        loop_active_d = loop_active_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
`ifdef SEQ_LOOP_EN
                    loop_cnt_d    = '0;
                    loop_active_d = 1'b0;
`endif
                end
            end

            S_FETCH: begin
                if (!stall) begin
                    ir_d    = imem_q[pc_q];
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                unique case (opcode)
                    OP_HALT: begin
                        state_d = S_DONE;
                    end
                    OP_LOAD_ADDR: begin
                        base_d  = ir_q[ADDR_W-1:0];
                        advance = 1'b1;
                    end
                    OP_LOAD_WEIGHT: begin
                        lw_d    = 1'b1;
                        advance = 1'b1;
                    end
                    OP_LOAD_INPUT: begin
                        li_d    = 1'b1;
                        advance = 1'b1;
                    end
                    OP_STORE: begin
                        st_d    = 1'b1;
                        advance = 1'b1;
                    end
                    OP_COMPUTE: begin
                        state_d = S_COMPUTE;
                        cnt_d   = '0;
                    end
`ifdef SEQ_LOOP_EN
                    OP_LOOP: begin
                        if (!loop_active_q) begin
                            // A zero repeat count never arms the loop.
                            if (loop_r == 5'd0) begin
                                advance = 1'b1;
                            end else begin
                                loop_cnt_d    = loop_r;
                                loop_active_d = 1'b1;
                                pc_d          = loop_tgt;
                                state_d       = S_FETCH;
                            end
                        end else if (loop_cnt_q > 5'd1) begin
                            loop_cnt_d = loop_cnt_q - 5'd1;
                            pc_d       = loop_tgt;
                            state_d    = S_FETCH;
                        end else begin
                            loop_active_d = 1'b0;
                            advance       = 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_d = S_ERROR;
                    end
                endcase
            end

            S_COMPUTE: begin
                // stall is deliberately not looked at: the valid burst is atomic.
                if (cnt_q == CNT_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completing the last memory slot ends the program instead of wrapping.
        if (advance) begin
            if (pc_q == PC_LAST) begin
                state_d = S_DONE;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            lw_q    <= 1'b0;
            li_q    <= 1'b0;
            st_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            lw_q    <= lw_d;
            li_q    <= li_d;
            st_q    <= st_d;
            // Status flags are registered decodes of the next state.
            valid_q <= (state_d == S_COMPUTE);
            busy_q  <= (state_d == S_FETCH) || (state_d == S_EXECUTE) ||
                       (state_d == S_COMPUTE);
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERROR);
        end
    end

`ifdef SEQ_LOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_cnt_q    <= '0;
            loop_active_q <= 1'b0;
        end else begin
            loop_cnt_q    <= loop_cnt_d;
            loop_active_q <= loop_active_d;
        end
    end
`endif

    assign base_address = base_q;
    assign load_weight  = lw_q;
    assign load_input   = li_q;
    assign store        = st_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Directed testbench for instruction_sequencer. Each program run is recorded
// cycle by cycle (index t = sample taken just after the t-th rising edge that
// follows the start request) and the trace is compared against hand-derived
// cycle numbers.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [12:0] base_address;
    logic        load_weight;
    logic        load_input;
    logic        store;
    logic        valid;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle trace of the most recent run.
    logic [63:0] tr_lw, tr_li, tr_st, tr_vld, tr_busy, tr_done, tr_err;
    logic [3:0]  tr_pc   [64];
    logic [12:0] tr_base [64];

    // Optional in-run events (sample index after which they are driven).
    int bs_t = -1;
    int wr_a = -1;
    int wr_b = -2;

    instruction_sequencer #(
        .IMEM_DEPTH     (16),
        .INSTR_W        (16),
        .ADDR_W         (13),
        .COMPUTE_CYCLES (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .base_address (base_address),
        .load_weight  (load_weight),
        .load_input   (load_input),
        .store        (store),
        .valid        (valid),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic imem_load(input int addr, input logic [15:0] data);
        imem_we    = 1'b1;
        imem_waddr = 4'(addr);
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
    endtask

    function automatic int first1(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int last1(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Pulse start, then record ncyc cycles. stall is high for the edges that
    // follow samples sa..sb and sc..sd.
    task automatic run_prog(input int ncyc, input int sa, input int sb,
                            input int sc, input int sd);
        tr_lw = '0; tr_li = '0; tr_st = '0; tr_vld = '0;
        tr_busy = '0; tr_done = '0; tr_err = '0;
        start = 1'b1;
        for (int t = 1; t <= ncyc; t++) begin
            tick();
            tr_lw[t]   = load_weight;
            tr_li[t]   = load_input;
            tr_st[t]   = store;
            tr_vld[t]  = valid;
            tr_busy[t] = busy;
            tr_done[t] = done;
            tr_err[t]  = error;
            tr_pc[t]   = pc;
            tr_base[t] = base_address;
            start   = (t == bs_t);
            stall   = (t >= sa && t <= sb) || (t >= sc && t <= sd);
            imem_we = (t >= wr_a && t <= wr_b);
        end
        start   = 1'b0;
        stall   = 1'b0;
        imem_we = 1'b0;
    endtask

    task automatic load_prog1();
        imem_load(0, 16'h200F);  // LOAD_ADDR 0x00F
        imem_load(1, 16'h4000);  // LOAD_WEIGHT
        imem_load(2, 16'h201E);  // LOAD_ADDR 0x01E
        imem_load(3, 16'h6000);  // LOAD_INPUT
        imem_load(4, 16'h8000);  // COMPUTE
        imem_load(5, 16'h2007);  // LOAD_ADDR 0x007
        imem_load(6, 16'hA000);  // STORE
        imem_load(7, 16'h0000);  // HALT
    endtask

    initial begin
        logic activity;

        reset      = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_eq("rst_pc",      32'(pc), 0);
        check_eq("rst_base",    32'(base_address), 0);
        check_eq("rst_busy",    32'(busy), 0);
        check_eq("rst_done",    32'(done), 0);
        check_eq("rst_error",   32'(error), 0);
        check_eq("rst_valid",   32'(valid), 0);
        check_eq("rst_strobes", 32'({load_weight, load_input, store}), 0);
        #2 reset = 1'b1;
        tick();

        // ---------------- basic program ----------------
        load_prog1();
        run_prog(26, -1, -2, -1, -2);
        check_eq("p1_base_t3",  32'(tr_base[3]), 32'h00F);
        check_eq("p1_base_t7",  32'(tr_base[7]), 32'h01E);
        check_eq("p1_base_t19", 32'(tr_base[19]), 32'h007);
        check_eq("p1_lw_first", first1(tr_lw), 5);
        check_eq("p1_lw_cnt",   $countones(tr_lw), 1);
        check_eq("p1_li_first", first1(tr_li), 9);
        check_eq("p1_li_cnt",   $countones(tr_li), 1);
        check_eq("p1_st_first", first1(tr_st), 21);
        check_eq("p1_st_cnt",   $countones(tr_st), 1);
        check_eq("p1_vld_first", first1(tr_vld), 11);
        check_eq("p1_vld_cnt",  $countones(tr_vld), 6);
        check_eq("p1_vld_span", last1(tr_vld) - first1(tr_vld) + 1, 6);
        check_eq("p1_done_first", first1(tr_done), 23);
        check_eq("p1_busy_t22", 32'(tr_busy[22]), 1);
        check_eq("p1_busy_t23", 32'(tr_busy[23]), 0);
        check_eq("p1_pc_end",   32'(tr_pc[26]), 7);

        // ---------------- stall in FETCH and in COMPUTE ----------------
        run_prog(30, 3, 6, 15, 17);
        check_eq("st_pc_hold_t7",  32'(tr_pc[7]), 1);
        check_eq("st_lw_first",    first1(tr_lw), 9);
        check_eq("st_li_first",    first1(tr_li), 13);
        check_eq("st_vld_first",   first1(tr_vld), 15);
        check_eq("st_vld_cnt",     $countones(tr_vld), 6);
        check_eq("st_vld_span",    last1(tr_vld) - first1(tr_vld) + 1, 6);
        check_eq("st_st_first",    first1(tr_st), 25);
        check_eq("st_done_first",  first1(tr_done), 27);

        // ---------------- illegal opcode at pc 3 ----------------
        imem_load(0, 16'h200F);
        imem_load(1, 16'h4000);
        imem_load(2, 16'h201E);
        imem_load(3, 16'hE000);  // opcode 111
        imem_load(4, 16'hA000);
        imem_load(5, 16'h0000);
        run_prog(14, -1, -2, -1, -2);
        check_eq("er_err_t8",    32'(tr_err[8]), 0);
        check_eq("er_err_first", first1(tr_err), 9);
        check_eq("er_pc_t9",     32'(tr_pc[9]), 3);
        check_eq("er_busy_t9",   32'(tr_busy[9]), 0);
        check_eq("er_pc_end",    32'(tr_pc[14]), 3);
        check_eq("er_lw_cnt",    $countones(tr_lw), 1);
        check_eq("er_li_cnt",    $countones(tr_li), 0);
        check_eq("er_st_cnt",    $countones(tr_st), 0);
        check_eq("er_done_cnt",  $countones(tr_done), 0);
        run_prog(10, -1, -2, -1, -2);
        check_eq("er2_err_t1",    32'(tr_err[1]), 0);
        check_eq("er2_busy_t1",   32'(tr_busy[1]), 1);
        check_eq("er2_err_first", first1(tr_err), 9);

        // ---------------- end of memory, writes and start while busy ----------
        for (int i = 0; i < 16; i++) begin
            imem_load(i, 16'h2000 | 16'(i));
        end
        imem_waddr = 4'd5;
        imem_wdata = 16'h0000;   // HALT, must not land while busy
        bs_t = 10;
        wr_a = 2;
        wr_b = 4;
        run_prog(40, -1, -2, -1, -2);
        bs_t = -1;
        wr_a = -1;
        wr_b = -2;
        check_eq("em_base_t13",   32'(tr_base[13]), 5);
        check_eq("em_busy_t32",   32'(tr_busy[32]), 1);
        check_eq("em_done_first", first1(tr_done), 33);
        check_eq("em_pc_t33",     32'(tr_pc[33]), 15);
        check_eq("em_pc_end",     32'(tr_pc[40]), 15);
        check_eq("em_base_end",   32'(tr_base[40]), 32'h00F);
        // Rerun with a write in the same cycle as start.
        imem_we    = 1'b1;
        imem_waddr = 4'd0;
        imem_wdata = 16'h20AA;
        run_prog(36, -1, -2, -1, -2);
        check_eq("em2_base_t3",    32'(tr_base[3]), 32'h0AA);
        check_eq("em2_base_t13",   32'(tr_base[13]), 5);
        check_eq("em2_done_first", first1(tr_done), 33);

        // ---------------- asynchronous reset during COMPUTE ----------------
        load_prog1();
        run_prog(13, -1, -2, -1, -2);
        check_eq("rs_vld_first", first1(tr_vld), 11);
        check_eq("rs_vld_t13",   32'(tr_vld[13]), 1);
        reset = 1'b0;
        #1;
        check_eq("rs_vld_async",  32'(valid), 0);
        check_eq("rs_busy_async", 32'(busy), 0);
        #2 reset = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            activity = activity | valid | busy | done | error |
                       load_weight | load_input | store | (pc != 4'd0);
        end
        check_eq("rs_idle_activity", 32'(activity), 0);
        check_eq("rs_idle_base",     32'(base_address), 0);

        // ---------------- LOOP opcode ----------------
        imem_load(0, 16'h8000);  // COMPUTE
        imem_load(1, 16'hC200);  // LOOP target 0, R=2
        imem_load(2, 16'h0000);  // HALT
`ifdef SEQ_LOOP_EN
        run_prog(36, -1, -2, -1, -2);
        check_eq("lp_vld_first",  first1(tr_vld), 3);
        check_eq("lp_vld_gap",    32'(tr_vld[10]), 0);
        check_eq("lp_vld_cnt",    $countones(tr_vld), 18);
        check_eq("lp_vld_last",   last1(tr_vld), 28);
        check_eq("lp_done_first", first1(tr_done), 33);
        check_eq("lp_err_cnt",    $countones(tr_err), 0);
`else
        run_prog(14, -1, -2, -1, -2);
        check_eq("lp_vld_cnt",    $countones(tr_vld), 6);
        check_eq("lp_err_first",  first1(tr_err), 11);
        check_eq("lp_pc_t11",     32'(tr_pc[11]), 1);
        check_eq("lp_done_cnt",   $countones(tr_done), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
